alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle sequencer that owns the shared `alu` datapath in the OrgaSmall core. It accepts one ALU instruction at a time over a valid/ready handshake and fetches both operands through the register file's single read port. It drives the external combinational `alu`, maintains the Z/N/C flag register, and writes the result back. ADC with carry set is executed as two ALU passes (ADD then INC).

## Interface
- `WORD_SIZE`, 16, datapath width
- `REG_ADDR_W`, 3, register-file address width

Ports (opcode type is `opcode_t` from shared `config.sv`):
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  instruction offered
- `req_ready`  out  1  sequencer idle, can accept
- `req_opcode`  in  opcode_t  operation
- `req_rx`  in  REG_ADDR_W  operand A register, also destination
- `req_ry`  in  REG_ADDR_W  operand B register
- `rf_raddr`  out  REG_ADDR_W  register-file read address; `rf_rdata` is valid one cycle later
- `rf_rdata`  in  WORD_SIZE  register-file read data
- `alu_a`, `alu_b`  out  WORD_SIZE  ALU operands
- `alu_opcode`  out  opcode_t  ALU operation
- `alu_out`  in  WORD_SIZE  ALU result (combinational)
- `rf_we`  out  1  write-back strobe
- `rf_waddr`  out  REG_ADDR_W  write-back address
- `rf_wdata`  out  WORD_SIZE  write-back data
- `flags`  out  3  {C, N, Z}
- `done`  out  1  one-cycle pulse when the instruction retires

## Operation
- States and transitions:
  - `IDLE`: go to `RD_X` on accept.
  - `RD_X`: go to `RD_Y`.
  - `RD_Y`: go to `EXEC`.
  - `EXEC`: go to `EXEC2` for ADC with C=1, otherwise `WB`.
  - `EXEC2`: go to `WB`.
  - `WB`: go to `IDLE`.
- `IDLE`: `req_ready`=1. Accept when `req_valid`=1, latching opcode, rx, ry.
- `RD_X`: `rf_raddr`=rx.
- `RD_Y`: `rf_raddr`=ry. Latch `rf_rdata` into A.
- `EXEC`:
  - Drive `alu_a`=A, `alu_b`=`rf_rdata`, `alu_opcode`=opcode.
  - Latch `alu_out` into R and B; update flags.
  - INC/DEC still perform the ry read; B is ignored.
- `EXEC2`: `alu_a`=R, `alu_b`=0, `alu_opcode`=INC. Latch R and update flags.
- `WB`:
  - `done`=1.
  - `rf_we`=1, `rf_waddr`=rx, `rf_wdata`=R, except for CMP and undefined opcodes, which have no write-back.
- Outside `EXEC`/`EXEC2`, the ALU outputs are 0 and `alu_opcode`=ADD.
- Flags for all defined opcodes except CMP:
  - Z = (R==0).
  - N = R[WORD_SIZE-1].
- Carry, computed by comparison on latched values, no wider adder:
  - ADD: C = (R < A), unsigned.
  - SUB: C = (A < B), borrow.
  - INC: C = (R==0).
  - DEC: C = (A==0).
  - ADC pass 1 as ADD; pass 2: C = C1 | (R==0).
  - AND/OR/XOR/SHL/SHR: C=0. Shift amounts ≥ WORD_SIZE yield 0, as the ALU does.
- CMP: Z = `alu_out`[0] (equal), C = (A < B), N = 0.
- Undefined opcode: flags unchanged, no write-back, `done` still pulses.
- `rf_rdata` values read while in `IDLE` are don't-care.

## Timing
- Accept in cycle 0. Reads in cycles 1–2. EXEC in cycle 3. WB/`done` in cycle 4, or cycle 5 for a two-pass ADC.
- `req_ready` rises the cycle after WB: 5 cycles per instruction (6 for two-pass ADC).
- New flags are visible on `flags` from the cycle after the EXEC/EXEC2 that wrote them.
- Back-to-back dependent instructions are safe: write-back completes before the next RD_X.
- Reset values: state `IDLE`, `flags`=0, `done`=0, `rf_we`=0, `req_ready`=1 (from the cycle after reset deasserts), all address/data outputs 0.
- `rst` in any state aborts the in-flight instruction: no write-back, no `done`, flags cleared.
- `req_valid` while not ready is ignored; the requester holds its request until the handshake.

## Configuration
- `ALU_SEQ_ADC_EN` defined: ADC with C=1 uses the two-pass sequence described in Operation.
- `ALU_SEQ_ADC_EN` undefined:
  - ADC is single-pass, identical to ADD including flags.
  - `EXEC2` is not built.
  - Latency is always 5 cycles.

## Test plan
- Reset, then ADD, R1=0x0003, R2=0x0004 → `rf_we` with `rf_waddr`=1, `rf_wdata`=0x0007 in cycle 4; `flags`=000; `done` one pulse.
- ADD 0xFFFF+0x0001, then ADC 0x0001+0x0001 → first gives R=0x0000, flags C=1, Z=1. Second (macro on) takes 6 cycles, writes 0x0003, C=0. With the macro off it writes 0x0002 in 5 cycles.
- SUB 0x0002−0x0005 → writes 0xFFFD, C=1, N=1, Z=0.
- CMP 0x1234 vs 0x1234 → no `rf_we`, Z=1, C=0, N=0. CMP 0x0001 vs 0x0002 → Z=0, C=1.
- Hold `req_valid` continuously with 3 queued ops → `req_ready` high only in IDLE, exactly one accept per 5 cycles, results in order.
- Assert `rst` during EXEC → no write-back, no `done`, `flags`=0, `req_ready`=1 the cycle after `rst` drops.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer: operand fetch over a single register-file read port, flag upkeep, write-back.
// Optional feature: define ALU_SEQ_ADC_EN to run ADC with C=1 as a second INC pass (state EXEC2).
`timescale 1ns/1ps

package alu_seq_pkg;
  typedef enum logic [4:0] {
    OP_ADD = 5'd1,
    OP_ADC = 5'd2,
    OP_SUB = 5'd3,
    OP_AND = 5'd4,
    OP_OR  = 5'd5,
    OP_XOR = 5'd6,
    OP_CMP = 5'd7,
    OP_INC = 5'd8,
    OP_DEC = 5'd9,
    OP_SHL = 5'd10,
    OP_SHR = 5'd11
  } opcode_t;
endpackage

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  opcode_t               req_opcode,
  input  logic [REG_ADDR_W-1:0] req_rx,
  input  logic [REG_ADDR_W-1:0] req_ry,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [WORD_SIZE-1:0]  rf_rdata,
  output logic [WORD_SIZE-1:0]  alu_a,
  output logic [WORD_SIZE-1:0]  alu_b,
  output opcode_t               alu_opcode,
  input  logic [WORD_SIZE-1:0]  alu_out,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WORD_SIZE-1:0]  rf_wdata,
  output logic [2:0]            flags,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_X  = 3'd1,
    S_RD_Y  = 3'd2,
    S_EXEC  = 3'd3,
`ifdef ALU_SEQ_ADC_EN
    S_EXEC2 = 3'd4,
`endif
    S_WB    = 3'd5
  } state_t;

  localparam int C_BIT = 2;

  state_t                r_state;
  opcode_t               r_op;
  logic [REG_ADDR_W-1:0] r_rx, r_ry, r_raddr, r_waddr;
  logic [WORD_SIZE-1:0]  r_a, r_res;
  logic [2:0]            r_flags;
  logic                  r_ready, r_we, r_done;

  logic [2:0] w_flags;
  logic       w_upd, w_wb, w_zero, w_msb, w_two_pass, w_to_wb;

  assign w_zero = (alu_out == '0);
  assign w_msb  = alu_out[WORD_SIZE-1];

`ifdef ALU_SEQ_ADC_EN
  assign w_two_pass = (r_op == OP_ADC) && r_flags[C_BIT];
  assign w_to_wb    = ((r_state == S_EXEC) && !w_two_pass) || (r_state == S_EXEC2);
`else
  assign w_two_pass = 1'b0;
  assign w_to_wb    = (r_state == S_EXEC);
`endif

  // Flags for the first (or only) pass; carry comes from comparisons on latched operands.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_flags = r_flags;
    w_upd   = 1'b1;
    w_wb    = 1'b1;
    case (r_op)
      OP_ADD, OP_ADC: w_flags = {alu_out < r_a, w_msb, w_zero};
      OP_SUB:         w_flags = {r_a < rf_rdata, w_msb, w_zero};
      OP_INC:         w_flags = {w_zero, w_msb, w_zero};
      OP_DEC:         w_flags = {r_a == '0, w_msb, w_zero};
      OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR:
                      w_flags = {1'b0, w_msb, w_zero};
      OP_CMP: begin
        w_flags = {r_a < rf_rdata, 1'b0, alu_out[0]};
        w_wb    = 1'b0;
      end
      default: begin
        w_upd = 1'b0;
        w_wb  = 1'b0;
      end
    endcase
  end

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = OP_ADD;
    case (r_state)
      S_EXEC: begin
        alu_a      = r_a;
        alu_b      = rf_rdata;
        alu_opcode = r_op;
      end
`ifdef ALU_SEQ_ADC_EN
      S_EXEC2: begin
        alu_a      = r_res;
        alu_opcode = OP_INC;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_rx    <= '0;
      r_ry    <= '0;
      r_raddr <= '0;
      r_waddr <= '0;
      r_a     <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_done  <= 1'b0;
      if (w_to_wb) begin
        r_done  <= 1'b1;
        r_we    <= w_wb;
        r_waddr <= w_wb ? r_rx : '0;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_opcode;
            r_rx    <= req_rx;
            r_ry    <= req_ry;
            r_raddr <= req_rx;
            r_ready <= 1'b0;
            r_state <= S_RD_X;
          end
        end
        S_RD_X: begin
          r_raddr <= r_ry;
          r_state <= S_RD_Y;
        end
        S_RD_Y: begin
          r_a     <= rf_rdata;
          r_raddr <= '0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_res <= alu_out;
          if (w_upd) r_flags <= w_flags;
`ifdef ALU_SEQ_ADC_EN
          r_state <= w_two_pass ? S_EXEC2 : S_WB;
`else
          r_state <= S_WB;
`endif
        end
`ifdef ALU_SEQ_ADC_EN
        S_EXEC2: begin
          // Carry out of the whole ADC is pass-1 carry or the +1 wrapping to zero.
          r_res   <= alu_out;
          r_flags <= {r_flags[C_BIT] | w_zero, w_msb, w_zero};
          r_state <= S_WB;
        end
`endif
        S_WB: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rf_raddr  = r_raddr;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_we ? r_res : '0;
  assign flags     = r_flags;
  assign done      = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: register file and combinational ALU models, vector table plus
// queued-request and mid-instruction reset sequences. Expectations follow ALU_SEQ_ADC_EN.
`timescale 1ns/1ps

module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_ready;
  opcode_t       req_opcode, alu_opcode;
  logic [AW-1:0] req_rx, req_ry, rf_raddr, rf_waddr;
  logic [W-1:0]  rf_rdata, alu_a, alu_b, alu_out, rf_wdata;
  logic          rf_we, done;
  logic [2:0]    flags;

  logic [W-1:0]  rf [8];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WORD_SIZE(W), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rx(req_rx), .req_ry(req_ry),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags(flags), .done(done)
  );

  // Register file: one synchronous read port (data next cycle), one write port, plus a bench load port.
  always @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (ld_en) rf[ld_addr] <= ld_data;
  end

  always_comb begin
    case (alu_opcode)
      OP_ADD, OP_ADC: alu_out = alu_a + alu_b;
      OP_SUB:         alu_out = alu_a - alu_b;
      OP_AND:         alu_out = alu_a & alu_b;
      OP_OR:          alu_out = alu_a | alu_b;
      OP_XOR:         alu_out = alu_a ^ alu_b;
      OP_CMP:         alu_out = {{(W-1){1'b0}}, alu_a == alu_b};
      OP_INC:         alu_out = alu_a + 16'd1;
      OP_DEC:         alu_out = alu_a - 16'd1;
      OP_SHL:         alu_out = (alu_b >= 16'd16) ? 16'd0 : alu_a << alu_b[3:0];
      OP_SHR:         alu_out = (alu_b >= 16'd16) ? 16'd0 : alu_a >> alu_b[3:0];
      default:        alu_out = 16'd0;
    endcase
  end

  typedef struct {
    opcode_t       op;
    logic [AW-1:0] rx;
    logic [AW-1:0] ry;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          we;
    logic [W-1:0]  wdata;
    logic [2:0]    flags;
    int            lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Issues one request; lat is the cycle (accept = cycle 0) in which done was seen, 0 on timeout.
  task automatic issue(input opcode_t op, input logic [AW-1:0] rx, input logic [AW-1:0] ry,
                       output int lat, output logic we, output logic [AW-1:0] wa,
                       output logic [W-1:0] wd, output logic [2:0] fl);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout: got 0x0, expected 0x1");
    end
    req_valid = 1'b1; req_opcode = op; req_rx = rx; req_ry = ry;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; we = 1'b0; wa = '0; wd = '0; fl = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i + 1; we = rf_we; wa = rf_waddr; wd = rf_wdata; fl = flags;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int            lat;
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [2:0]    fl;
    logic          seen_done, seen_we, rdy;
    opcode_t       q_op [3];
    logic [AW-1:0] q_rx [3], q_ry [3], q_ea [3];
    logic [W-1:0]  q_ed [3];
    int            acc_cyc [3];
    int            idx, nw;

    //           op                  rx    ry    x         y         we    wdata     flags   lat
    vecs[0]  = '{OP_ADD,             3'd1, 3'd2, 16'h0003, 16'h0004, 1'b1, 16'h0007, 3'b000, 4};
    vecs[1]  = '{OP_ADD,             3'd3, 3'd4, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 3'b101, 4};
`ifdef ALU_SEQ_ADC_EN
    vecs[2]  = '{OP_ADC,             3'd1, 3'd2, 16'h0001, 16'h0001, 1'b1, 16'h0003, 3'b000, 5};
`else
    vecs[2]  = '{OP_ADC,             3'd1, 3'd2, 16'h0001, 16'h0001, 1'b1, 16'h0002, 3'b000, 4};
`endif
    vecs[3]  = '{OP_SUB,             3'd5, 3'd6, 16'h0002, 16'h0005, 1'b1, 16'hFFFD, 3'b110, 4};
    vecs[4]  = '{OP_CMP,             3'd1, 3'd2, 16'h1234, 16'h1234, 1'b0, 16'h0000, 3'b001, 4};
    vecs[5]  = '{OP_CMP,             3'd1, 3'd2, 16'h0001, 16'h0002, 1'b0, 16'h0000, 3'b100, 4};
`ifdef ALU_SEQ_ADC_EN
    vecs[6]  = '{OP_ADC,             3'd2, 3'd1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 3'b101, 5};
`else
    vecs[6]  = '{OP_ADC,             3'd2, 3'd1, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 3'b010, 4};
`endif
    vecs[7]  = '{OP_INC,             3'd7, 3'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 3'b101, 4};
    vecs[8]  = '{OP_DEC,             3'd1, 3'd2, 16'h0000, 16'h0007, 1'b1, 16'hFFFF, 3'b110, 4};
    vecs[9]  = '{OP_AND,             3'd1, 3'd2, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 3'b000, 4};
    vecs[10] = '{OP_OR,              3'd4, 3'd3, 16'h8000, 16'h0001, 1'b1, 16'h8001, 3'b010, 4};
    vecs[11] = '{OP_XOR,             3'd1, 3'd2, 16'hAAAA, 16'hAAAA, 1'b1, 16'h0000, 3'b001, 4};
    vecs[12] = '{OP_SHL,             3'd1, 3'd2, 16'h0001, 16'h000F, 1'b1, 16'h8000, 3'b010, 4};
    vecs[13] = '{OP_SHL,             3'd1, 3'd2, 16'h0001, 16'h0010, 1'b1, 16'h0000, 3'b001, 4};
    vecs[14] = '{OP_SHR,             3'd1, 3'd2, 16'h8000, 16'h0004, 1'b1, 16'h0800, 3'b000, 4};
    vecs[15] = '{OP_ADC,             3'd1, 3'd2, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 3'b010, 4};
    vecs[16] = '{opcode_t'(5'h1F),   3'd1, 3'd2, 16'h0001, 16'h0002, 1'b0, 16'h0000, 3'b010, 4};

    rst = 1'b1; req_valid = 1'b0; req_opcode = OP_ADD; req_rx = '0; req_ry = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_we", 32'(rf_we), 32'h0);
    check("rst_raddr", 32'(rf_raddr), 32'h0);
    check("rst_waddr", 32'(rf_waddr), 32'h0);
    check("rst_wdata", 32'(rf_wdata), 32'h0);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_op", 32'(alu_opcode), 32'(OP_ADD));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("rst_ready", 32'(req_ready), 32'h1);

    // Vector table.
    for (int i = 0; i < 17; i++) begin
      load(vecs[i].rx, vecs[i].x);
      load(vecs[i].ry, vecs[i].y);
      issue(vecs[i].op, vecs[i].rx, vecs[i].ry, lat, we, wa, wd, fl);
      check($sformatf("v%0d_done_cycle", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d_waddr", i), 32'(wa), 32'(vecs[i].rx));
        check($sformatf("v%0d_wdata", i), 32'(wd), 32'(vecs[i].wdata));
      end
      check($sformatf("v%0d_flags", i), 32'(fl), 32'(vecs[i].flags));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
      check($sformatf("v%0d_ready_after", i), 32'(req_ready), 32'h1);
    end

    // Reset asserted during EXEC aborts the instruction and clears flags.
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0006);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = OP_ADD; req_rx = 3'd1; req_ry = 3'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("exec_alu_a", 32'(alu_a), 32'h0005);
    check("exec_alu_b", 32'(alu_b), 32'h0006);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_done", 32'(done), 32'h0);
    check("abort_we", 32'(rf_we), 32'h0);
    check("abort_flags", 32'(flags), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0; seen_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) check("abort_ready", 32'(req_ready), 32'h1);
      seen_done |= done;
      seen_we   |= rf_we;
    end
    check("abort_no_done", 32'(seen_done), 32'h0);
    check("abort_no_we", 32'(seen_we), 32'h0);
    check("abort_r1_kept", 32'(rf[1]), 32'h0005);

    // Three dependent requests with req_valid held continuously.
    load(3'd1, 16'h0001);
    load(3'd2, 16'h0002);
    load(3'd3, 16'h000A);
    q_op[0] = OP_ADD; q_rx[0] = 3'd1; q_ry[0] = 3'd2; q_ea[0] = 3'd1; q_ed[0] = 16'h0003;
    q_op[1] = OP_ADD; q_rx[1] = 3'd1; q_ry[1] = 3'd1; q_ea[1] = 3'd1; q_ed[1] = 16'h0006;
    q_op[2] = OP_SUB; q_rx[2] = 3'd3; q_ry[2] = 3'd1; q_ea[2] = 3'd3; q_ed[2] = 16'h0004;
    idx = 0; nw = 0;
    for (int c = 0; c < 3; c++) acc_cyc[c] = -100;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (idx < 3) begin
        req_valid = 1'b1; req_opcode = q_op[idx]; req_rx = q_rx[idx]; req_ry = q_ry[idx];
      end else begin
        req_valid = 1'b0;
      end
      rdy = req_ready;
      @(posedge clk);
      if (rdy && req_valid) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      #1;
      if (rf_we) begin
        if (nw < 3) begin
          check($sformatf("q%0d_waddr", nw), 32'(rf_waddr), 32'(q_ea[nw]));
          check($sformatf("q%0d_wdata", nw), 32'(rf_wdata), 32'(q_ed[nw]));
        end
        nw++;
      end
    end
    req_valid = 1'b0;
    check("q_accepts", 32'(idx), 32'd3);
    check("q_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
    check("q_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
    check("q_writes", 32'(nw), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
